// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a big-endian byte program into a 32-bit wide
// instruction memory. It holds the CPU via busy while loading and flags
// short final words or overflow on the sticky error output.
// Optional build macro: INSTR_MEM_ZERO_FILL_EN adds a FILL state. FILL
// zero-writes every word after the program up to DEPTH-1.
module instr_mem_loader #(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count
);

    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef INSTR_MEM_ZERO_FILL_EN
        FILL,
`endif
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      byte_idx;
    logic [IW-1:0]   word_idx;
    logic            last_seen;
    logic [31:0]     word_buf;
    logic            accept;
    logic            at_last_idx;
    logic [31:0]     addr_cur;

    assign accept      = in_valid && in_ready;
    assign at_last_idx = (word_idx == LAST_IDX);
    assign addr_cur    = BASE_ADDR + (32'(word_idx) << 2);

    // State register; reset drops straight back to IDLE without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and all FSM outputs; mem bus stays zero outside writes
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_data  = 32'h0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (in_last || byte_idx == 2'd3)) state_nxt = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_cur;
                mem_data = word_buf;
                if (last_seen || at_last_idx) begin
`ifdef INSTR_MEM_ZERO_FILL_EN
                    if (!at_last_idx) state_nxt = FILL;
                    else              state_nxt = DONE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = COLLECT;
                end
            end
`ifdef INSTR_MEM_ZERO_FILL_EN
            FILL: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_cur;
                mem_data = 32'h0;
                if (at_last_idx) state_nxt = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load bookkeeping: byte/word indices, word count, last marker, sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            word_idx   <= '0;
            word_count <= 8'd0;
            last_seen  <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx   <= 2'd0;
                        word_idx   <= '0;
                        word_count <= 8'd0;
                        last_seen  <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (in_last) begin
                            last_seen <= 1'b1;
                            byte_idx  <= 2'd0;
                            if (byte_idx != 2'd3) error <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    word_idx   <= word_idx + IW'(1);
                    word_count <= word_count + 8'd1;
                    if (at_last_idx && !last_seen) error <= 1'b1;
                end
`ifdef INSTR_MEM_ZERO_FILL_EN
                FILL: begin
                    word_idx <= word_idx + IW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Word assembly: byte 0 lands in [31:24] and clears the lower lanes so a
    // short final word is zero padded
    always_ff @(posedge clk) begin
        if (accept) begin
            case (byte_idx)
                2'd0:    word_buf        <= {in_byte, 24'h0};
                2'd1:    word_buf[23:16] <= in_byte;
                2'd2:    word_buf[15:8]  <= in_byte;
                default: word_buf[7:0]   <= in_byte;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (DEPTH=4). The byte stream, the write
// log and the flags are checked against hand-computed values.
module tb_instr_mem_loader;

    localparam int DEPTH_T = 4;
`ifdef INSTR_MEM_ZERO_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr, mem_data;
    logic [7:0]  word_count;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    instr_mem_loader #(.DEPTH(DEPTH_T), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and hold it until the edge that accepts it
    task automatic send(input logic [7:0] b, input logic last);
        int n;
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) chk("send_ready", {31'b0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("done", {31'b0, done}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_mem_we"},   {31'b0, mem_we},   32'd0);
        chk({tag, "_mem_addr"}, mem_addr,          32'd0);
        chk({tag, "_mem_data"}, mem_data,          32'd0);
        chk({tag, "_busy"},     {31'b0, busy},     32'd0);
        chk({tag, "_done"},     {31'b0, done},     32'd0);
        chk({tag, "_error"},    {31'b0, error},    32'd0);
        chk({tag, "_wcount"},   {24'b0, word_count}, 32'd0);
    endtask

    initial begin
        int fill_n;
        // Reset with no clock edge yet
        #1 reset = 1'b1;
        #1 chk_all_zero("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_all_zero("idle");

        // One-word program 8C010004
        wa.delete(); wd.delete();
        pulse_start();
        chk("c0_busy", {31'b0, busy}, 32'd1);
        chk("c0_ready", {31'b0, in_ready}, 32'd1);
        send(8'h8C, 1'b0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h04, 1'b1);
        idle_inputs();
        chk("t1_we", {31'b0, mem_we}, 32'd1);
        chk("t1_addr", mem_addr, 32'h0);
        chk("t1_data", mem_data, 32'h8C010004);
        chk("t1_ready_wr", {31'b0, in_ready}, 32'd0);
        wait_done();
        chk("t1_wcount", {24'b0, word_count}, 32'd1);
        chk("t1_error", {31'b0, error}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        fill_n = FILL_ON ? DEPTH_T - 1 : 0;
        chk("t1_nwrites", 32'(wa.size()), 32'(1 + fill_n));
        if (wa.size() > 0) chk("t1_log_data", wd[0], 32'h8C010004);
        for (int i = 1; i <= fill_n; i++) begin
            if (wa.size() > i) begin
                chk("fill_addr", wa[i], 32'(4 * i));
                chk("fill_data", wd[i], 32'h0);
            end
        end

        // Two words with in_valid toggling
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            tick();
            send(8'h11 * (i + 1), i == 7);
            if (i == 3 || i == 7) begin
                chk("t2_ready_wr", {31'b0, in_ready}, 32'd0);
                chk("t2_we", {31'b0, mem_we}, 32'd1);
            end
            if (i == 3) begin
                chk("t2_data0", mem_data, 32'h11223344);
                idle_inputs();
                tick();
                chk("t2_ready_back", {31'b0, in_ready}, 32'd1);
                chk("t2_we_off", {31'b0, mem_we}, 32'd0);
            end
        end
        idle_inputs();
        wait_done();
        chk("t2_wcount", {24'b0, word_count}, 32'd2);
        chk("t2_error", {31'b0, error}, 32'd0);
        if (wa.size() >= 2) begin
            chk("t2_addr0", wa[0], 32'h0);
            chk("t2_addr1", wa[1], 32'h4);
            chk("t2_log1", wd[1], 32'h55667788);
        end else chk("t2_nwrites", 32'(wa.size()), 32'd2);

        // Short final word AA BB
        wa.delete(); wd.delete();
        pulse_start();
        chk("t3_err_clr", {31'b0, error}, 32'd0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        idle_inputs();
        chk("t3_addr", mem_addr, 32'h0);
        chk("t3_data", mem_data, 32'hAABB0000);
        wait_done();
        chk("t3_error", {31'b0, error}, 32'd1);
        chk("t3_wcount", {24'b0, word_count}, 32'd1);

        // Overflow: 16 bytes fill DEPTH=4, no in_last
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        idle_inputs();
        wait_done();
        chk("t4_error", {31'b0, error}, 32'd1);
        chk("t4_wcount", {24'b0, word_count}, 32'd4);
        in_byte = 8'h11; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        idle_inputs();
        chk("t4_nwrites", 32'(wa.size()), 32'd4);
        if (wa.size() >= 4) begin
            chk("t4_addr3", wa[3], 32'hC);
            chk("t4_data0", wd[0], 32'h01020304);
            chk("t4_data3", wd[3], 32'h0D0E0F10);
        end

        // Reset during byte 2 of word 3
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        in_byte = 8'h0A; in_valid = 1'b1;
        #2 reset = 1'b1;
        #1 chk_all_zero("abort");
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();
        chk("t5_nwrites", 32'(wa.size()), 32'd2);
        pulse_start();
        send(8'hCA, 1'b0);
        send(8'hFE, 1'b0);
        send(8'hBA, 1'b0);
        send(8'hBE, 1'b1);
        idle_inputs();
        chk("t5_addr", mem_addr, 32'h0);
        chk("t5_data", mem_data, 32'hCAFEBABE);
        wait_done();
        chk("t5_wcount", {24'b0, word_count}, 32'd1);
        chk("t5_error", {31'b0, error}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
